star_bbox_scan: RTL and testbench
=================================

STAR_BBOX_SCAN -- requirements
Module: star_bbox_scan

Interface
REQ-001 SHALL have parameters: X_SZ 8 (x coordinate width); Y_SZ 7 (y coordinate width); COL_SZ 3 (pixel width); X_RES 160 (image width); Y_RES 120 (image height); THRESHOLD 0 (a pixel value <= THRESHOLD is dark).
REQ-002 SHALL have ports:
- clk  in  1  single clock, all state on rising edge.
- reset  in  1  asynchronous, active-high.
- start  in  1  seed valid, one-cycle strobe.
- x_in  in  X_SZ  seed x.
- y_in  in  Y_SZ  seed y.
- rd_x  out  X_SZ  pixel read x.
- rd_y  out  Y_SZ  pixel read y.
- rd_pix  in  COL_SZ  read data; valid exactly 1 cycle after rd_x/rd_y are presented.
- busy  out  1  scan in progress.
- done  out  1  one-cycle completion pulse.
- err  out  1  one-cycle pulse on rejected seed, coincident with done.
- most_left, most_right, mid_x  out  X_SZ  horizontal extent and centre.
- most_top, most_bottom, mid_y  out  Y_SZ  vertical extent and centre.

Function
REQ-003 SHALL run an FSM with states IDLE, SCAN_R, SCAN_L, SCAN_D, SCAN_U, FIN; each SCAN state alternates ISSUE (drive probe address) and CHECK (evaluate rd_pix) sub-phases, so each probe costs 2 cycles.
REQ-004 In IDLE, start SHALL be sampled: an in-range seed is latched and the FSM enters SCAN_R; start while busy SHALL be ignored.
REQ-005 A seed with x_in >= X_RES or y_in >= Y_RES SHALL be rejected: next cycle done=1 and err=1, all extent outputs unchanged, FSM stays IDLE.
REQ-006 The seed pixel SHALL NOT be probed; it is bright by definition.
REQ-007 SCAN_R SHALL probe (x_in+1, y_in), (x_in+2, y_in), ...; most_right = last bright x; stop on the first dark pixel or after the probe at x = X_RES-1.
REQ-008 SCAN_L SHALL probe x_in-1, x_in-2, ... on row y_in; most_left = last bright x; stop on dark or after x = 0.
REQ-009 A direction whose seed already lies on that image edge SHALL perform zero probes, with extent = seed coordinate.
REQ-010 On leaving SCAN_L, mid_x SHALL be set to (most_left + most_right) >> 1, summed at X_SZ+1 bits with no overflow.
REQ-011 SCAN_D then SCAN_U SHALL probe column mid_x from y_in downward (+1) and upward (-1); most_bottom and most_top follow the same rules as REQ-007 to REQ-009, with edges Y_RES-1 and 0.
REQ-012 mid_y SHALL be (most_top + most_bottom) >> 1, summed at Y_SZ+1 bits.
REQ-013 FIN SHALL assert done=1 for exactly one cycle, then return to IDLE; busy=1 in all states except IDLE.
REQ-014 Latency: done SHALL assert 2*P+2 cycles after the start edge, where P = total probes over all four directions.
REQ-015 Extent and mid outputs SHALL be registered, SHALL update only in FIN, and SHALL hold until the next successful FIN.
REQ-016 rd_x/rd_y SHALL hold the last probe address while IDLE; no pixel read SHALL be evaluated outside CHECK.

Reset
REQ-017 On reset assertion, at any time including mid-scan, the FSM SHALL go to IDLE immediately.
REQ-018 On reset, busy, done, err and all coordinate outputs (rd_x, rd_y, extents, mid) SHALL be 0.
REQ-019 After reset deasserts, the first start SHALL begin a fresh scan; no partial result SHALL ever appear on the outputs.

Verification
REQ-020 3x3 bright block at x 10..12, y 20..22, seed (11,21): P=8 -> done at cycle 18; left 10, right 12, top 20, bottom 22, mid (11,21).
REQ-021 Seed (159,119) with the whole image bright: right and down make zero probes; left runs to 0, up runs to 0; extents 0/159/0/119, mid (79,59).
REQ-022 Seed (160,5) -> one cycle later done=1, err=1, previous outputs unchanged, busy stays 0.
REQ-023 start pulsed again mid-scan -> ignored; the original result is delivered intact.
REQ-024 Reset asserted during SCAN_D -> outputs 0 immediately; a new start yields a correct full result.
REQ-025 Isolated single bright pixel at (0,0), seed (0,0): right and down each probe one dark pixel -> P=2, done at cycle 6, all extents 0.

Source files
------------

// File: rtl/star_bbox_scan.sv
// Bounding-box scanner: walks a seed pixel's row right/left, then the centre column
// down/up, through a 1-cycle-latency pixel port, and reports extents plus centre.
module star_bbox_scan #(
  parameter int X_SZ      = 8,
  parameter int Y_SZ      = 7,
  parameter int COL_SZ    = 3,
  parameter int X_RES     = 160,
  parameter int Y_RES     = 120,
  parameter int THRESHOLD = 0
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              start,
  input  logic [X_SZ-1:0]   x_in,
  input  logic [Y_SZ-1:0]   y_in,
  output logic [X_SZ-1:0]   rd_x,
  output logic [Y_SZ-1:0]   rd_y,
  input  logic [COL_SZ-1:0] rd_pix,
  output logic              busy,
  output logic              done,
  output logic              err,
  output logic [X_SZ-1:0]   most_left,
  output logic [X_SZ-1:0]   most_right,
  output logic [X_SZ-1:0]   mid_x,
  output logic [Y_SZ-1:0]   most_top,
  output logic [Y_SZ-1:0]   most_bottom,
  output logic [Y_SZ-1:0]   mid_y
);

  typedef enum logic [2:0] {IDLE, SCAN_R, SCAN_L, SCAN_D, SCAN_U, FIN} state_t;

  localparam logic [X_SZ-1:0] X_MAX = X_SZ'(X_RES - 1);
  localparam logic [Y_SZ-1:0] Y_MAX = Y_SZ'(Y_RES - 1);
  localparam logic [X_SZ:0]   X_LIM = (X_SZ+1)'(X_RES);
  localparam logic [Y_SZ:0]   Y_LIM = (Y_SZ+1)'(Y_RES);

  state_t state, stateNext;
  logic   chk, chkNext;   // 0 = ISSUE sub-phase, 1 = CHECK sub-phase

  logic [X_SZ-1:0] seedX, curL, curR, nL, nR, sx, midXNext, rdXNext;
  logic [Y_SZ-1:0] seedY, curT, curB, nT, nB, sy, midYCur, rdYNext;
  logic [X_SZ:0]   sumX;
  logic [Y_SZ:0]   sumY;
  logic            seedOk, accept, bright, inScan, atEdge, cont, leave;
  logic            hasR, hasL, hasD, hasU;
  state_t          dirAfter;

  // First direction at or after 'from' that has at least one pixel to probe.
  function automatic state_t pickDir(input state_t from, input logic [3:0] avail);
    int first;
    case (from)
      IDLE:    first = 0;
      SCAN_R:  first = 1;
      SCAN_L:  first = 2;
      SCAN_D:  first = 3;
      default: first = 4;
    endcase
    pickDir = FIN;
    for (int i = 3; i >= 0; i--) begin
      if (avail[i] && i >= first) begin
        case (i)
          0:       pickDir = SCAN_R;
          1:       pickDir = SCAN_L;
          2:       pickDir = SCAN_D;
          default: pickDir = SCAN_U;
        endcase
      end
    end
  endfunction

  // Seed is taken straight from the inputs while idle so the first probe can issue at once.
  assign sx     = (state == IDLE) ? x_in : seedX;
  assign sy     = (state == IDLE) ? y_in : seedY;
  assign seedOk = ({1'b0, x_in} < X_LIM) && ({1'b0, y_in} < Y_LIM);
  assign accept = (state == IDLE) && start && seedOk;
  assign bright = rd_pix > COL_SZ'(THRESHOLD);
  assign inScan = (state == SCAN_R) || (state == SCAN_L) || (state == SCAN_D) || (state == SCAN_U);
  assign hasR   = sx != X_MAX;
  assign hasL   = sx != '0;
  assign hasD   = sy != Y_MAX;
  assign hasU   = sy != '0;
  assign dirAfter = pickDir(state, {hasU, hasD, hasL, hasR});

  always_comb begin
    atEdge = 1'b0;
    case (state)
      SCAN_R:  atEdge = rd_x == X_MAX;
      SCAN_L:  atEdge = rd_x == '0;
      SCAN_D:  atEdge = rd_y == Y_MAX;
      SCAN_U:  atEdge = rd_y == '0;
      default: atEdge = 1'b0;
    endcase
  end

  assign cont  = inScan && chk && bright && !atEdge;
  assign leave = accept || (inScan && chk && !cont);

  // FSM: state register
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state <= IDLE;
      chk   <= 1'b0;
    end else begin
      state <= stateNext;
      chk   <= chkNext;
    end
  end

  // FSM: next state
  always_comb begin
    stateNext = state;
    chkNext   = chk;
    case (state)
      IDLE: begin
        if (accept) begin
          stateNext = dirAfter;
          chkNext   = 1'b0;
        end
      end
      SCAN_R, SCAN_L, SCAN_D, SCAN_U: begin
        if (!chk) chkNext = 1'b1;
        else begin
          chkNext = 1'b0;
          if (!cont) stateNext = dirAfter;
        end
      end
      FIN:     stateNext = IDLE;
      default: stateNext = IDLE;
    endcase
  end

  // FSM: outputs
  always_comb begin
    busy = state != IDLE;
  end

  // Running extents; a bright CHECK pushes the extent of the active direction out.
  always_comb begin
    nL = curL;
    nR = curR;
    nT = curT;
    nB = curB;
    if (accept) begin
      nL = x_in;
      nR = x_in;
      nT = y_in;
      nB = y_in;
    end else if (inScan && chk && bright) begin
      case (state)
        SCAN_R:  nR = rd_x;
        SCAN_L:  nL = rd_x;
        SCAN_D:  nB = rd_y;
        default: nT = rd_y;
      endcase
    end
  end

  // Column for the vertical scans; stays constant once the horizontal pass is over.
  assign sumX     = {1'b0, nL} + {1'b0, nR};
  assign midXNext = sumX[X_SZ:1];
  assign sumY     = {1'b0, curT} + {1'b0, curB};
  assign midYCur  = sumY[Y_SZ:1];

  always_comb begin
    rdXNext = rd_x;
    rdYNext = rd_y;
    if (leave) begin
      case (dirAfter)
        SCAN_R: begin rdXNext = sx + 1'b1; rdYNext = sy;        end
        SCAN_L: begin rdXNext = sx - 1'b1; rdYNext = sy;        end
        SCAN_D: begin rdXNext = midXNext;  rdYNext = sy + 1'b1; end
        SCAN_U: begin rdXNext = midXNext;  rdYNext = sy - 1'b1; end
        default: begin rdXNext = rd_x;     rdYNext = rd_y;      end
      endcase
    end else if (cont) begin
      case (state)
        SCAN_R:  rdXNext = rd_x + 1'b1;
        SCAN_L:  rdXNext = rd_x - 1'b1;
        SCAN_D:  rdYNext = rd_y + 1'b1;
        default: rdYNext = rd_y - 1'b1;
      endcase
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      seedX       <= '0;
      seedY       <= '0;
      curL        <= '0;
      curR        <= '0;
      curT        <= '0;
      curB        <= '0;
      rd_x        <= '0;
      rd_y        <= '0;
      done        <= 1'b0;
      err         <= 1'b0;
      most_left   <= '0;
      most_right  <= '0;
      mid_x       <= '0;
      most_top    <= '0;
      most_bottom <= '0;
      mid_y       <= '0;
    end else begin
      if (accept) begin
        seedX <= x_in;
        seedY <= y_in;
      end
      curL <= nL;
      curR <= nR;
      curT <= nT;
      curB <= nB;
      rd_x <= rdXNext;
      rd_y <= rdYNext;
      done <= 1'b0;
      err  <= 1'b0;
      if (state == IDLE && start && !seedOk) begin
        done <= 1'b1;
        err  <= 1'b1;
      end
      // Results become visible only as a complete set.
      if (state == FIN) begin
        done        <= 1'b1;
        most_left   <= curL;
        most_right  <= curR;
        mid_x       <= midXNext;
        most_top    <= curT;
        most_bottom <= curB;
        mid_y       <= midYCur;
      end
    end
  end

endmodule

// File: tb/tb_star_bbox_scan.sv
// Randomised bench for star_bbox_scan: an array image feeds the pixel port, a loop-based
// model predicts each result, and a monitor compares every done pulse against a queue.
module tb_star_bbox_scan;
  localparam int XR = 160;
  localparam int YR = 120;
  localparam int TH = 0;

  logic       clk = 1'b0;
  logic       reset, start;
  logic [7:0] x_in, rd_x, most_left, most_right, mid_x;
  logic [6:0] y_in, rd_y, most_top, most_bottom, mid_y;
  logic [2:0] rd_pix;
  logic       busy, done, err;

  star_bbox_scan #(.X_SZ(8), .Y_SZ(7), .COL_SZ(3), .X_RES(XR), .Y_RES(YR), .THRESHOLD(TH)) dut (
    .clk(clk), .reset(reset), .start(start), .x_in(x_in), .y_in(y_in),
    .rd_x(rd_x), .rd_y(rd_y), .rd_pix(rd_pix), .busy(busy), .done(done), .err(err),
    .most_left(most_left), .most_right(most_right), .mid_x(mid_x),
    .most_top(most_top), .most_bottom(most_bottom), .mid_y(mid_y));

  always #5 clk = ~clk;

  logic [2:0] img [XR][YR];
  always @(posedge clk) rd_pix <= (rd_x < XR && rd_y < YR) ? img[rd_x][rd_y] : 3'd0;

  typedef struct {
    logic err;
    int   l, r, t, b, mx, my, lat, stamp;
  } exp_t;

  exp_t sb[$];
  exp_t lastGood;
  int   ncmp = 0, nerr = 0, ncnt = 0;

  task automatic chk(input string n, input int got, input int want);
    ncmp++;
    if (got != want) begin
      nerr++;
      $display("FAIL %s got %0d expected %0d", n, got, want);
    end
  endtask

  function automatic bit isBright(input int x, input int y);
    return img[x][y] > TH;
  endfunction

  // Walk outward from the seed until dark or the image edge; P counts probed pixels.
  task automatic model(input int sx, input int sy, output exp_t e, output int pH);
    int p;
    pH = 0;
    if (sx >= XR || sy >= YR) begin
      e = lastGood; e.err = 1'b1; e.lat = 1;
      return;
    end
    p = 0;
    e.err = 1'b0;
    e.r = sx;
    for (int x = sx + 1; x < XR; x++) begin p++; if (!isBright(x, sy)) break; e.r = x; end
    e.l = sx;
    for (int x = sx - 1; x >= 0; x--) begin p++; if (!isBright(x, sy)) break; e.l = x; end
    pH = p;
    e.mx = (e.l + e.r) / 2;
    e.b = sy;
    for (int y = sy + 1; y < YR; y++) begin p++; if (!isBright(e.mx, y)) break; e.b = y; end
    e.t = sy;
    for (int y = sy - 1; y >= 0; y--) begin p++; if (!isBright(e.mx, y)) break; e.t = y; end
    e.my  = (e.t + e.b) / 2;
    e.lat = 2 * p + 2;
    lastGood = e;
  endtask

  // Monitor: latency is negedges from the one before the start edge to the one seeing done.
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      ncnt++;
      if (done) begin
        if (sb.size() == 0) begin
          ncmp++; nerr++;
          $display("FAIL unexpected_done got 1 expected 0");
        end else begin
          e = sb.pop_front();
          chk("err", err, e.err);
          chk("latency", ncnt - e.stamp, e.lat);
          chk("busy_at_done", busy, 0);
          chk("most_left", most_left, e.l);
          chk("most_right", most_right, e.r);
          chk("mid_x", mid_x, e.mx);
          chk("most_top", most_top, e.t);
          chk("most_bottom", most_bottom, e.b);
          chk("mid_y", mid_y, e.my);
        end
      end
    end
  end

  task automatic waitDrain();
    for (int i = 0; i < 3000; i++) begin
      if (sb.size() == 0) break;
      @(posedge clk);
    end
    if (sb.size() != 0) begin
      ncmp++; nerr++;
      $display("FAIL done_timeout got %0d pending expected 0", sb.size());
      sb.delete();
    end
    repeat (2) @(posedge clk);
  endtask

  task automatic scan(input int sx, input int sy, input bit midPulse);
    exp_t e;
    int   pH;
    model(sx, sy, e, pH);
    @(posedge clk); #1;
    e.stamp = ncnt + 1;
    sb.push_back(e);
    start = 1'b1; x_in = 8'(sx); y_in = 7'(sy);
    @(posedge clk); #1;
    start = 1'b0;
    if (midPulse && e.lat > 12) begin
      repeat (3) @(posedge clk);
      #1;
      start = 1'b1; x_in = 8'($urandom_range(0, 255)); y_in = 7'($urandom_range(0, 127));
      @(posedge clk); #1;
      start = 1'b0;
    end
    waitDrain();
  endtask

  task automatic checkZero(input string tag);
    chk({tag, "_busy"}, busy, 0);
    chk({tag, "_done"}, done, 0);
    chk({tag, "_err"}, err, 0);
    chk({tag, "_rd_x"}, rd_x, 0);
    chk({tag, "_rd_y"}, rd_y, 0);
    chk({tag, "_left"}, most_left, 0);
    chk({tag, "_right"}, most_right, 0);
    chk({tag, "_mid_x"}, mid_x, 0);
    chk({tag, "_top"}, most_top, 0);
    chk({tag, "_bottom"}, most_bottom, 0);
    chk({tag, "_mid_y"}, mid_y, 0);
  endtask

  // Starts a scan and hits reset during the ISSUE cycle of the first downward probe.
  task automatic resetInScanD(input int sx, input int sy);
    exp_t e;
    int   pH;
    model(sx, sy, e, pH);
    @(posedge clk); #1;
    start = 1'b1; x_in = 8'(sx); y_in = 7'(sy);
    @(posedge clk); #1;
    start = 1'b0;
    repeat (2 * pH) @(posedge clk);
    #2 reset = 1'b1;
    #1 checkZero("rst_mid");
    lastGood = '{err: 1'b0, l: 0, r: 0, t: 0, b: 0, mx: 0, my: 0, lat: 0, stamp: 0};
    repeat (2) @(posedge clk);
    #1 reset = 1'b0;
    repeat (2) @(posedge clk);
  endtask

  task automatic fillImg(input int pct);
    for (int x = 0; x < XR; x++)
      for (int y = 0; y < YR; y++)
        img[x][y] = (pct > 0 && $urandom_range(0, 99) < pct) ? 3'($urandom_range(1, 7)) : 3'd0;
  endtask

  task automatic blockImg();
    fillImg(0);
    for (int x = 10; x <= 12; x++)
      for (int y = 20; y <= 22; y++) img[x][y] = 3'd5;
  endtask

  initial begin
    int sx, sy, k;
    reset = 1'b1; start = 1'b0; x_in = '0; y_in = '0;
    lastGood = '{err: 1'b0, l: 0, r: 0, t: 0, b: 0, mx: 0, my: 0, lat: 0, stamp: 0};
    fillImg(0);
    repeat (3) @(posedge clk);
    #1 checkZero("init");
    reset = 1'b0;
    repeat (2) @(posedge clk);

    blockImg();
    scan(11, 21, 1'b0);
    scan(160, 5, 1'b0);
    scan(11, 21, 1'b1);

    fillImg(100);
    scan(159, 119, 1'b0);

    fillImg(0);
    img[0][0] = 3'd7;
    scan(0, 0, 1'b0);

    blockImg();
    resetInScanD(11, 21);
    scan(5, 120, 1'b0);
    scan(11, 21, 1'b0);

    for (int it = 0; it < 20; it++) begin
      fillImg(80);
      k = $urandom_range(0, 9);
      if (k == 0) begin
        sx = $urandom_range(0, 255); sy = $urandom_range(120, 127);
      end else if (k == 1) begin
        sx = $urandom_range(160, 255); sy = $urandom_range(0, 127);
      end else if (k < 4) begin
        sx = ($urandom_range(0, 1) != 0) ? XR - 1 : 0;
        sy = ($urandom_range(0, 1) != 0) ? YR - 1 : $urandom_range(0, YR - 1);
      end else begin
        sx = $urandom_range(0, XR - 1); sy = $urandom_range(0, YR - 1);
      end
      if (sx < XR && sy < YR) img[sx][sy] = 3'd3;
      scan(sx, sy, $urandom_range(0, 3) == 0);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", ncmp, nerr);
    $finish;
  end
endmodule
